mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the pipeline's instruction fetch and data access stages share a single, multi-cycle, single-ported physical memory. Each requester sees the same hold-until-`resp` handshake as the dual-ported simulation memory, so fetch/data logic is unchanged when the physical memory is swapped in. The block serialises requests, registers the selected request onto the memory bus, waits a variable number of cycles for the memory to respond, and returns a one-cycle response with read data to the granted requester.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 14 +
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and grant encodings for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
    localparam int BE_W = 2;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin picker
// Ports: i_req[0]=I side, i_req[1]=D side, i_last_grant = previous winner, o_grant = pick
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  grant_t     i_last_grant,
    output grant_t     o_grant
);
    // On a tie the port that did not win last time goes; otherwise the sole requester.
    // With no request the output is don't-care and defaults to GRANT_I.
    assign o_grant = (&i_req) ? ((i_last_grant == GRANT_I) ? GRANT_D : GRANT_I)
                              : (i_req[1] ? GRANT_D : GRANT_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle single-ported memory between fetch (i_*) and data (d_*) ports
// Ports: clk/rst; per-port read/write/byte_enable/address/wdata in, resp/rdata out;
//        registered mem_* request bus out, mem_resp/mem_rdata in
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [BE_W-1:0]   i_byte_enable,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byte_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_t        r_state, w_next;
    grant_t            r_grant, r_last, w_pick;
    logic              r_mem_read, r_mem_write;
    logic [BE_W-1:0]   r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
    logic              w_i_req, w_d_req, w_sel_read, w_sel_write;

    assign w_i_req = i_read | i_write;
    assign w_d_req = d_read | d_write;

    rr_arbiter2 u_rr (
        .i_req        ({w_d_req, w_i_req}),
        .i_last_grant (r_last),
        .o_grant      (w_pick)
    );

    // A read+write request is a write.
    assign w_sel_write = (w_pick == GRANT_D) ? d_write : i_write;
    assign w_sel_read  = ((w_pick == GRANT_D) ? d_read : i_read) & ~w_sel_write;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? ((w_i_req | w_d_req) ? BUSY : IDLE)
               : (r_state == BUSY) ? (mem_resp ? RESP : BUSY)
               : IDLE;
    end

    always_comb begin
        i_resp = (r_state == RESP) && (r_grant == GRANT_I);
        d_resp = (r_state == RESP) && (r_grant == GRANT_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= GRANT_I;
            r_last      <= GRANT_I;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else if (r_state == IDLE && (w_i_req | w_d_req)) begin
            r_grant     <= w_pick;
            r_last      <= w_pick;
            r_mem_read  <= w_sel_read;
            r_mem_write <= w_sel_write;
            r_mem_be    <= (w_pick == GRANT_D) ? d_byte_enable : i_byte_enable;
            r_mem_addr  <= (w_pick == GRANT_D) ? d_address : i_address;
            r_mem_wdata <= (w_pick == GRANT_D) ? d_wdata : i_wdata;
        end else if (r_state == BUSY && mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read && r_grant == GRANT_I) r_i_rdata <= mem_rdata;
            if (r_mem_read && r_grant == GRANT_D) r_d_rdata <= mem_rdata;
        end
    end

    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_mem_be;
    assign mem_address     = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign i_rdata         = r_i_rdata;
    assign d_rdata         = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a round-robin reference model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read = 0, i_write = 0, d_read = 0, d_write = 0;
    logic [1:0]  i_byte_enable = 0, d_byte_enable = 0;
    logic [15:0] i_address = 0, i_wdata = 0, d_address = 0, d_wdata = 0;
    logic        i_resp, d_resp;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp = 0;
    logic [15:0] mem_rdata = 0;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: per-port pending request (0 = I, 1 = D), last winner, rdata per port
    logic        pend [2];
    logic        rd [2];
    logic        wr [2];
    logic [1:0]  be [2];
    logic [15:0] addr [2];
    logic [15:0] wd [2];
    logic [15:0] model_rdata [2];
    int          model_last;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_byte_enable(i_byte_enable),
        .i_address(i_address), .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        i_read = pend[0] & rd[0];  i_write = pend[0] & wr[0];
        d_read = pend[1] & rd[1];  d_write = pend[1] & wr[1];
        i_byte_enable = be[0]; i_address = addr[0]; i_wdata = wd[0];
        d_byte_enable = be[1]; d_address = addr[1]; d_wdata = wd[1];
    endtask

    task automatic set_req(input int p, input logic r, input logic w, input logic [1:0] b,
                           input logic [15:0] a, input logic [15:0] d);
        pend[p] = 1; rd[p] = r; wr[p] = w; be[p] = b; addr[p] = a; wd[p] = d;
    endtask

    task automatic new_req(input int p);
        int k;
        k = $urandom_range(0, 2);
        set_req(p, k != 1, k != 0, 2'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        rst = 1; mem_resp = 0;
        pend[0] = 0; pend[1] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_last = 0;
        model_rdata[0] = 0; model_rdata[1] = 0;
        check("rst_resp", {i_resp, d_resp}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_mem", {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata}, 0);
    endtask

    // One arbitration + memory transaction; called #1 after an edge with the DUT idle.
    task automatic txn(input int lat, input logic [15:0] rdat);
        int w;
        logic is_rd;
        w = (pend[0] && pend[1]) ? 1 - model_last : (pend[1] ? 1 : 0);
        model_last = w;
        is_rd = rd[w] && !wr[w];
        @(posedge clk); #1;
        for (int c = 0; c < lat; c++) begin
            check("mem_read", mem_read, is_rd);
            check("mem_write", mem_write, wr[w]);
            check("mem_address", mem_address, addr[w]);
            check("mem_wdata", mem_wdata, wd[w]);
            check("mem_be", mem_byte_enable, be[w]);
            check("busy_resp", {i_resp, d_resp}, 0);
            if (c == lat - 1) begin
                mem_resp = 1; mem_rdata = rdat;
            end else if (!pend[1-w] && $urandom_range(0, 1) == 1) begin
                new_req(1 - w); drive();
            end
            @(posedge clk); #1;
        end
        mem_resp = 0; mem_rdata = 16'($urandom);
        if (is_rd) model_rdata[w] = rdat;
        check("i_resp", i_resp, w == 0);
        check("d_resp", d_resp, w == 1);
        check("i_rdata", i_rdata, model_rdata[0]);
        check("d_rdata", d_rdata, model_rdata[1]);
        check("mem_cleared", {mem_read, mem_write}, 0);
        @(posedge clk); #1;
        check("resp_drop", {i_resp, d_resp}, 0);
        pend[w] = 0;
        drive();
    endtask

    task automatic stray_idle();
        mem_resp = 1; mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        mem_resp = 0;
        check("stray_resp", {i_resp, d_resp}, 0);
        check("stray_mem", {mem_read, mem_write}, 0);
        check("stray_rdata_i", i_rdata, model_rdata[0]);
        check("stray_rdata_d", d_rdata, model_rdata[1]);
    endtask

    initial begin
        do_reset();
        // I-read only, 3-cycle memory
        set_req(0, 1, 0, 2'b11, 16'h3000, 16'h0); drive();
        txn(3, 16'h1234);
        check("d_resp_quiet", d_resp, 0);
        // tie after reset: D first, then I
        do_reset();
        set_req(0, 1, 0, 2'b11, 16'h3000, 16'h0);
        set_req(1, 0, 1, 2'b10, 16'h4000, 16'hBEEF); drive();
        txn(2, 16'h5555);
        txn(2, 16'h6666);
        // sustained contention, 4 each
        for (int k = 0; k < 8; k++) begin
            if (!pend[0]) new_req(0);
            if (!pend[1]) new_req(1);
            drive();
            txn($urandom_range(1, 3), 16'($urandom));
        end
        // D read, then D read+write with 1-cycle memory keeps d_rdata
        pend[0] = 0;
        set_req(1, 1, 0, 2'b11, 16'h0040, 16'h0); drive();
        txn(1, 16'hA5A5);
        set_req(1, 1, 1, 2'b01, 16'h0042, 16'h7777); drive();
        txn(1, 16'h9999);
        check("rw_keeps_rdata", d_rdata, 16'hA5A5);
        // reset while busy, then stray mem_resp in IDLE
        do_reset();
        set_req(0, 1, 0, 2'b11, 16'h3000, 16'h0); drive();
        @(posedge clk); #1;
        check("pre_rst_read", mem_read, 1);
        pend[0] = 0; drive();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_busy_resp", {i_resp, d_resp}, 0);
        check("rst_busy_mem", {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata}, 0);
        model_last = 0;
        stray_idle();
        @(posedge clk); #1;
        check("post_stray_resp", {i_resp, d_resp}, 0);
        // randomized mix
        for (int k = 0; k < 60; k++) begin
            if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) stray_idle();
            if (!pend[0] && $urandom_range(0, 1) == 1) new_req(0);
            if (!pend[1] && (!pend[0] || $urandom_range(0, 1) == 1)) new_req(1);
            drive();
            txn($urandom_range(1, 4), 16'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
